// File: rtl/mux_arb_pkg.sv
// Shared types and sizing for the round-robin mux arbiter.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: the first set request bit found
// searching upward (wrapping) from ptr wins.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   winner,
  output logic               any_valid
);

  // Requests rotated so that bit 0 is the requester at ptr.
  logic [NUM_REQ-1:0] rot;
  logic [SEL_W-1:0]   offset;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign rot[gi] = req[ptr + SEL_W'(gi)];
    end
  endgenerate

  // Lowest set bit of the rotated vector gives the distance from ptr.
  always_comb begin
    offset = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) offset = SEL_W'(k);
    end
  end

  assign winner    = ptr + offset;
  assign any_valid = |req;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Four-lane round-robin burst arbiter with a registered output stage.
// A grant is held until the requester marks its last beat or MAX_BURST
// beats have been moved; the pointer then advances past the winner.
module rr_mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [3:0]         req_valid,
  input  logic [3:0]         req_last,
  input  logic [WIDTH-1:0]   in0,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [WIDTH-1:0]   in3,
  output logic [3:0]         req_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [1:0]         out_sel
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  state_t             state_q;
  logic [SEL_W-1:0]   ptr_q;
  logic [SEL_W-1:0]   sel_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_data_q;
  logic               out_last_q;

  logic [WIDTH-1:0]   lane [NUM_REQ];
  logic [SEL_W-1:0]   winner;
  logic               any_valid;
  logic               accept_ok;
  logic               xfer;
  logic               burst_done;
  logic [CNT_W-1:0]   cnt_d;
  logic [SEL_W-1:0]   ptr_d;

  assign lane[0] = in0;
  assign lane[1] = in1;
  assign lane[2] = in2;
  assign lane[3] = in3;

  rr_pick4 u_pick (
    .req       (req_valid),
    .ptr       (ptr_q),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // The granted lane may push a beat when the output register is empty
  // or is being drained in the same cycle.
  assign accept_ok  = (state_q == BURST) && (!out_valid_q || out_ready);
  assign xfer       = accept_ok && req_valid[sel_q];
  assign cnt_d      = cnt_q + CNT_W'(1);
  assign ptr_d      = sel_q + SEL_W'(1);
  assign burst_done = xfer && (req_last[sel_q] || (cnt_d == CNT_W'(MAX_BURST)));

  // One-hot ready towards the granted requester only.
  always_comb begin
    req_ready = '0;
    if (accept_ok) req_ready[sel_q] = 1'b1;
  end

  // Arbitration FSM plus output register; reset drops any pending beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable && any_valid) begin
            state_q <= BURST;
            sel_q   <= winner;
            cnt_q   <= '0;
          end
        end
        BURST: begin
          if (xfer) begin
            cnt_q <= cnt_d;
            if (burst_done) begin
              state_q <= IDLE;
              ptr_q   <= ptr_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= lane[sel_q];
        out_last_q  <= req_last[sel_q];
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: a per-cycle vector table covering
// latency, rotation, multi-beat bursts, back-pressure, forced release and
// idle grants, followed by an asynchronous reset sequence.
module tb_rr_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] req_valid = '0;
  logic [3:0] req_last = '0;
  logic [7:0] in0 = 8'h55;
  logic [7:0] in1 = 8'hAA;
  logic [7:0] in2 = 8'hCC;
  logic [7:0] in3 = 8'hF0;
  logic [3:0] req_ready;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic [1:0] out_sel;

  int checks = 0;
  int failures = 0;

  rr_mux_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .req_valid (req_valid),
    .req_last  (req_last),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       en;
    logic [3:0] rv;
    logic [3:0] rl;
    logic       ordy;
    logic [3:0] rr;
    logic       ov;
    logic [7:0] od;
    logic       ol;
    logic [1:0] os;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic en, input logic [3:0] rv,
                     input logic [3:0] rl, input logic ordy, input logic [3:0] rr,
                     input logic ov, input logic [7:0] od, input logic ol,
                     input logic [1:0] os);
    vec_t v;
    v.name = n; v.en = en; v.rv = rv; v.rl = rl; v.ordy = ordy;
    v.rr = rr; v.ov = ov; v.od = od; v.ol = ol; v.os = os;
    vecs.push_back(v);
  endtask

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, act, exp);
    end
  endtask

  task automatic chk_all(input string n, input logic [3:0] rr, input logic ov,
                         input logic [7:0] od, input logic ol, input logic [1:0] os);
    chk({n, ".req_ready"}, {4'b0, req_ready}, {4'b0, rr});
    chk({n, ".out_valid"}, {7'b0, out_valid}, {7'b0, ov});
    chk({n, ".out_data"},  out_data, od);
    chk({n, ".out_last"},  {7'b0, out_last}, {7'b0, ol});
    chk({n, ".out_sel"},   {6'b0, out_sel}, {6'b0, os});
  endtask

  initial begin
    // Single-beat request from requester 1: grant next cycle, data after.
    add("a0", 1, 4'b0010, 4'b0010, 1, 4'b0000, 0, 8'h00, 0, 0);
    add("a1", 1, 4'b0010, 4'b0010, 1, 4'b0010, 0, 8'h00, 0, 1);
    add("a2", 1, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'hAA, 1, 1);
    // Pointer now at 2: requester 3 must beat requester 1.
    add("a3", 1, 4'b1010, 4'b1010, 1, 4'b0000, 0, 8'hAA, 1, 1);
    add("a4", 1, 4'b1010, 4'b1010, 1, 4'b1000, 0, 8'hAA, 1, 3);
    add("a5", 1, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'hF0, 1, 3);
    // All four requesting single beats: 55, AA, CC, F0, 55 every 2 cycles.
    add("b0", 1, 4'b1111, 4'b1111, 1, 4'b0000, 0, 8'hF0, 1, 3);
    add("b1", 1, 4'b1111, 4'b1111, 1, 4'b0001, 0, 8'hF0, 1, 0);
    add("b2", 1, 4'b1111, 4'b1111, 1, 4'b0000, 1, 8'h55, 1, 0);
    add("b3", 1, 4'b1111, 4'b1111, 1, 4'b0010, 0, 8'h55, 1, 1);
    add("b4", 1, 4'b1111, 4'b1111, 1, 4'b0000, 1, 8'hAA, 1, 1);
    add("b5", 1, 4'b1111, 4'b1111, 1, 4'b0100, 0, 8'hAA, 1, 2);
    add("b6", 1, 4'b1111, 4'b1111, 1, 4'b0000, 1, 8'hCC, 1, 2);
    add("b7", 1, 4'b1111, 4'b1111, 1, 4'b1000, 0, 8'hCC, 1, 3);
    add("b8", 1, 4'b1111, 4'b1111, 1, 4'b0000, 1, 8'hF0, 1, 3);
    add("b9", 1, 4'b1111, 4'b1111, 1, 4'b0001, 0, 8'hF0, 1, 0);
    add("b10", 1, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'h55, 1, 0);
    // Requester 2 three-beat burst while requester 0 waits.
    add("c0", 1, 4'b0101, 4'b0001, 1, 4'b0000, 0, 8'h55, 1, 0);
    add("c1", 1, 4'b0101, 4'b0001, 1, 4'b0100, 0, 8'h55, 1, 2);
    add("c2", 1, 4'b0101, 4'b0001, 1, 4'b0100, 1, 8'hCC, 0, 2);
    add("c3", 1, 4'b0101, 4'b0101, 1, 4'b0100, 1, 8'hCC, 0, 2);
    add("c4", 1, 4'b0001, 4'b0001, 1, 4'b0000, 1, 8'hCC, 1, 2);
    add("c5", 1, 4'b0001, 4'b0001, 1, 4'b0001, 0, 8'hCC, 1, 0);
    add("c6", 1, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'h55, 1, 0);
    // Downstream stalls three cycles mid-burst.
    add("d0", 1, 4'b0010, 4'b0000, 1, 4'b0000, 0, 8'h55, 1, 0);
    add("d1", 1, 4'b0010, 4'b0000, 1, 4'b0010, 0, 8'h55, 1, 1);
    add("d2", 1, 4'b0010, 4'b0010, 0, 4'b0000, 1, 8'hAA, 0, 1);
    add("d3", 1, 4'b0010, 4'b0010, 0, 4'b0000, 1, 8'hAA, 0, 1);
    add("d4", 1, 4'b0010, 4'b0010, 0, 4'b0000, 1, 8'hAA, 0, 1);
    add("d5", 1, 4'b0010, 4'b0010, 1, 4'b0010, 1, 8'hAA, 0, 1);
    add("d6", 1, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'hAA, 1, 1);
    add("d7", 1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 8'hAA, 1, 1);
    // Requester 3 forced off after 4 beats, enable low, requester 1 first.
    add("e0", 1, 4'b1010, 4'b0000, 1, 4'b0000, 0, 8'hAA, 1, 1);
    add("e1", 1, 4'b1010, 4'b0000, 1, 4'b1000, 0, 8'hAA, 1, 3);
    add("e2", 0, 4'b1010, 4'b0000, 1, 4'b1000, 1, 8'hF0, 0, 3);
    add("e3", 0, 4'b1010, 4'b0000, 1, 4'b1000, 1, 8'hF0, 0, 3);
    add("e4", 0, 4'b1010, 4'b0000, 1, 4'b1000, 1, 8'hF0, 0, 3);
    add("e5", 0, 4'b1010, 4'b0000, 1, 4'b0000, 1, 8'hF0, 0, 3);
    add("e6", 0, 4'b1010, 4'b0000, 1, 4'b0000, 0, 8'hF0, 0, 3);
    add("e7", 1, 4'b1010, 4'b0010, 1, 4'b0000, 0, 8'hF0, 0, 3);
    add("e8", 1, 4'b1010, 4'b0010, 1, 4'b0010, 0, 8'hF0, 0, 1);
    add("e9", 1, 4'b1000, 4'b0000, 1, 4'b0000, 1, 8'hAA, 1, 1);
    add("e10", 1, 4'b1000, 4'b0000, 1, 4'b1000, 0, 8'hAA, 1, 3);
    add("e11", 1, 4'b1000, 4'b1000, 1, 4'b1000, 1, 8'hF0, 0, 3);
    add("e12", 1, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'hF0, 1, 3);
    add("e13", 1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 8'hF0, 1, 3);
    // Granted requester goes quiet: grant held, idle cycles do not count.
    add("f0", 1, 4'b0001, 4'b0000, 1, 4'b0000, 0, 8'hF0, 1, 3);
    for (int i = 0; i < 5; i++)
      add($sformatf("f1_%0d", i), 1, 4'b0000, 4'b0000, 1, 4'b0001, 0, 8'hF0, 1, 0);
    add("f2", 1, 4'b0100, 4'b0000, 1, 4'b0001, 0, 8'hF0, 1, 0);
    add("f3", 1, 4'b0001, 4'b0001, 1, 4'b0001, 0, 8'hF0, 1, 0);
    add("f4", 1, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'h55, 1, 0);

    // Reset state.
    @(negedge clk);
    #1;
    chk_all("reset", 4'b0000, 0, 8'h00, 0, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      enable    = vecs[i].en;
      req_valid = vecs[i].rv;
      req_last  = vecs[i].rl;
      out_ready = vecs[i].ordy;
      #1;
      chk_all(vecs[i].name, vecs[i].rr, vecs[i].ov, vecs[i].od, vecs[i].ol, vecs[i].os);
      $display("vec %s rv=%b rdy=%b ov=%0d od=%0h ol=%0d sel=%0d",
               vecs[i].name, vecs[i].rv, req_ready, out_valid, out_data, out_last, out_sel);
    end

    // Asynchronous reset in the middle of a stalled burst (pointer is 1).
    @(negedge clk);
    enable = 1'b1; req_valid = 4'b0100; req_last = 4'b0000; out_ready = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk_all("rst_pre", 4'b0000, 1, 8'hCC, 0, 2);
    #1;
    rst = 1'b1;
    #1;
    chk_all("rst_async", 4'b0000, 0, 8'h00, 0, 0);
    $display("rst asserted mid-burst ov=%0d od=%0h sel=%0d", out_valid, out_data, out_sel);
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst_quiet%0d.out_valid", i), {7'b0, out_valid}, 8'h00);
    end
    // Pointer restarts at 0: requester 0 wins over requester 3.
    req_valid = 4'b1001; req_last = 4'b1001; out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_regrant.out_sel", {6'b0, out_sel}, 8'h00);
    chk("rst_regrant.req_ready", {4'b0, req_ready}, 8'h01);
    @(negedge clk);
    req_valid = 4'b0000; req_last = 4'b0000;
    #1;
    chk("rst_beat.out_valid", {7'b0, out_valid}, 8'h01);
    chk("rst_beat.out_data", out_data, 8'h55);
    $display("post-reset grant sel=%0d od=%0h", out_sel, out_data);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
